// File: rtl/fifo_pkg.sv
// Shared sizing and state encoding for the FIFO write-port arbiter.
package fifo_pkg;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int COUNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer request/grant bus plus the FIFO write side and occupancy status.
interface fifo_wr_arbiter_if
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         data_in;
  logic                      write_en;
  logic                      read_en;
  logic [COUNT_W-1:0]        count;
  logic                      full;
  logic                      empty;
  logic                      underflow_err;

  modport slave (
    input  req, req_data, req_last, read_en,
    output gnt, data_in, write_en, count, full, empty, underflow_err
  );

  modport master (
    output req, req_data, req_last, read_en,
    input  gnt, data_in, write_en, count, full, empty, underflow_err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of i_req at or after i_ptr, wrapping.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_valid,
  output logic [N-1:0]         o_onehot,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int IDX_W = $clog2(N);

  int w_j;

  always_comb begin
    o_valid  = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    w_j      = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!o_valid && i_req[w_j]) begin
        o_valid       = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx         = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharing of one FIFO write port with credit-based overflow guard.
// state | meaning:  ARB = pick next owner (gnt=0)  |  BURST = owner granted while credit allows
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);
  localparam logic [COUNT_W:0] DEPTH_C = (COUNT_W + 1)'(DEPTH);

  arb_state_t          r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_owner, w_owner_nxt;
  logic [NUM_REQ-1:0]  r_owner_oh, w_owner_oh_nxt;
  logic [IDX_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [BEAT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;

  logic                r_write_en;
  logic [DATA_W-1:0]   r_data_in;
  logic [COUNT_W-1:0]  r_count;
  logic                r_underflow;

  logic                w_pick_valid;
  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [IDX_W-1:0]    w_pick_idx;
  logic [COUNT_W:0]    w_fill;
  logic                w_credit_ok;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_accept;
  logic                w_owner_req;
  logic                w_owner_last;
  logic [DATA_W-1:0]   w_owner_data;
  logic [IDX_W-1:0]    w_ptr_after_owner;
  logic                w_pop;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .i_req    (bus.req),
    .i_ptr    (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx)
  );

  // The registered write still in flight counts against capacity; a same-cycle read does not.
  assign w_fill      = {1'b0, r_count} + {{COUNT_W{1'b0}}, r_write_en};
  assign w_credit_ok = w_fill < DEPTH_C;

  assign w_gnt        = (r_state == BURST && w_credit_ok) ? r_owner_oh : '0;
  assign w_accept     = |(bus.req & w_gnt);
  assign w_owner_req  = |(bus.req & r_owner_oh);
  assign w_owner_last = |(bus.req_last & r_owner_oh);
  assign w_pop        = bus.read_en && (r_count != '0);

  assign w_ptr_after_owner = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  always_comb begin
    w_owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner_oh[i]) w_owner_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_owner_oh_nxt = r_owner_oh;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ARB: begin
        if (w_pick_valid) begin
          w_state_nxt    = BURST;
          w_owner_nxt    = w_pick_idx;
          w_owner_oh_nxt = w_pick_oh;
          w_beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (w_accept) begin
          if (w_owner_last || r_beat_cnt == BEAT_W'(BURST_MAX - 1)) begin
            w_state_nxt  = ARB;
            w_rr_ptr_nxt = w_ptr_after_owner;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
          end
        end else if (!w_owner_req && w_credit_ok) begin
          // Owner went quiet while it could have sent: release the port.
          w_state_nxt  = ARB;
          w_rr_ptr_nxt = w_ptr_after_owner;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_owner    <= '0;
      r_owner_oh <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_owner_oh <= w_owner_oh_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_en  <= 1'b0;
      r_data_in   <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_write_en <= w_accept;
      if (w_accept) r_data_in <= w_owner_data;
      case ({r_write_en, w_pop})
        2'b10:   r_count <= r_count + COUNT_W'(1);
        2'b01:   r_count <= r_count - COUNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (bus.read_en && r_count == '0) r_underflow <= 1'b1;
    end
  end

  assign bus.gnt           = w_gnt;
  assign bus.write_en      = r_write_en;
  assign bus.data_in       = r_data_in;
  assign bus.count         = r_count;
  assign bus.full          = (r_count == COUNT_W'(DEPTH));
  assign bus.empty         = (r_count == '0);
  assign bus.underflow_err = r_underflow;

endmodule
